uart_frame_rx: RTL and testbench

- Downstream consumer of the uart block's receive side.
- Pops bytes from the UART RX FIFO through `rd_uart`, `rx_empty` and `r_data`, and parses them into command frames: SYNC, CMD, LEN, PAYLOAD[LEN], CSUM.
- Payload is stored in an internal buffer and presented to the host logic with a valid/ack handshake.
- Reports length, checksum and inter-byte-timeout errors.

---
 rtl/uart_frame_pkg.sv | 32 +++
 rtl/uart_frame_rx_if.sv | 43 ++++
 rtl/frame_payload_ram.sv | 39 +++
 rtl/uart_frame_rx.sv | 155 +++++++++++++++
 tb/tb_uart_frame_rx.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// uart_frame_pkg : shared constants, types and width helpers for uart_frame_rx
// Revision       : 1.0
// ============================================================================
package uart_frame_pkg;

  localparam int DATA_W  = 8;
  localparam int STATE_W = 3;

  typedef logic [DATA_W-1:0] byte_t;

  localparam byte_t DEFAULT_SYNC_BYTE = 8'hA5;

  localparam logic [STATE_W-1:0] HUNT    = 3'd0;
  localparam logic [STATE_W-1:0] CMD     = 3'd1;
  localparam logic [STATE_W-1:0] LEN     = 3'd2;
  localparam logic [STATE_W-1:0] PAYLOAD = 3'd3;
  localparam logic [STATE_W-1:0] CHECK   = 3'd4;
  localparam logic [STATE_W-1:0] HOLD    = 3'd5;

  // Width of a length field able to hold 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_rx_if.sv
`default_nettype none
// ============================================================================
// uart_frame_rx_if : UART RX FIFO pop port plus host frame/buffer/error port
// Revision         : 1.0
// ============================================================================
interface uart_frame_rx_if
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN = 16
);

  localparam int LEN_W  = len_width(MAX_LEN);
  localparam int ADDR_W = addr_width(MAX_LEN);

  logic              rx_empty;
  logic [DATA_W-1:0] r_data;
  logic              rd_uart;

  logic              frame_valid;
  logic              frame_ack;
  logic [DATA_W-1:0] frame_cmd;
  logic [LEN_W-1:0]  frame_len;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  logic              err_len;
  logic              err_csum;
  logic              err_timeout;

  modport master (
    input  rx_empty, r_data, frame_ack, buf_addr,
    output rd_uart, frame_valid, frame_cmd, frame_len, buf_data,
           err_len, err_csum, err_timeout
  );

  modport slave (
    output rx_empty, r_data, frame_ack, buf_addr,
    input  rd_uart, frame_valid, frame_cmd, frame_len, buf_data,
           err_len, err_csum, err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/frame_payload_ram.sv
`default_nettype none
// ============================================================================
// frame_payload_ram : single write port, registered read port payload store
// Revision          : 1.0
// ============================================================================
module frame_payload_ram
  import uart_frame_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = addr_width(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [DATA_W-1:0] rdata
);

  // Storage carries no reset so it maps onto plain RAM cells.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else begin
      rdata <= r_mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// uart_frame_rx : pops a UART RX FIFO and parses SYNC/CMD/LEN/PAYLOAD/CSUM frames
// Revision      : 1.0
// ============================================================================
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int          MAX_LEN   = 16,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int          TIMEOUT   = 50000,
  parameter int          TO_W      = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  uart_frame_rx_if.master bus
);

  localparam int                LEN_W     = len_width(MAX_LEN);
  localparam int                ADDR_W    = addr_width(MAX_LEN);
  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [LEN_W-1:0]  ONE_L     = LEN_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  logic [STATE_W-1:0] r_state;
  logic [DATA_W-1:0]  r_csum;
  logic [ADDR_W-1:0]  r_idx;
  logic [DATA_W-1:0]  r_frame_cmd;
  logic [LEN_W-1:0]   r_frame_len;
  logic               r_frame_valid;
  logic               r_err_len;
  logic               r_err_csum;
  logic               r_err_timeout;
  logic [TO_W-1:0]    r_to_cnt;

  logic               w_pop;
  logic               w_active;
  logic               w_last;
  logic               w_ram_we;
  logic [DATA_W-1:0]  w_byte;
  logic [DATA_W-1:0]  w_buf_data;

  assign w_pop    = !bus.rx_empty && (r_state != HOLD);
  assign w_byte   = bus.r_data;
  assign w_active = (r_state == CMD) || (r_state == LEN) ||
                    (r_state == PAYLOAD) || (r_state == CHECK);
  assign w_last   = (LEN_W'(r_idx) == (r_frame_len - ONE_L));
  assign w_ram_we = w_pop && (r_state == PAYLOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= HUNT;
      r_csum        <= '0;
      r_idx         <= '0;
      r_frame_cmd   <= '0;
      r_frame_len   <= '0;
      r_frame_valid <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_csum    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_err_len     <= 1'b0;
      r_err_csum    <= 1'b0;
      r_err_timeout <= 1'b0;

      // Idle cycles inside a frame count toward the timeout; a pop, HUNT or HOLD clears it.
      if (w_active && !w_pop) begin
        if (r_to_cnt == TO_LAST) begin
          r_err_timeout <= 1'b1;
          r_state       <= HUNT;
          r_to_cnt      <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end

      if (w_pop) begin
        case (r_state)
          HUNT: begin
            if (w_byte == SYNC_BYTE) begin
              r_state <= CMD;
            end
          end
          CMD: begin
            r_frame_cmd <= w_byte;
            r_csum      <= w_byte;
            r_state     <= LEN;
          end
          LEN: begin
            if (w_byte > MAX_LEN_B) begin
              r_err_len <= 1'b1;
              r_state   <= HUNT;
            end else begin
              r_frame_len <= LEN_W'(w_byte);
              r_csum      <= r_csum + w_byte;
              r_idx       <= '0;
              r_state     <= (w_byte == 8'h00) ? CHECK : PAYLOAD;
            end
          end
          PAYLOAD: begin
            r_csum <= r_csum + w_byte;
            r_idx  <= r_idx + 1'b1;
            if (w_last) begin
              r_state <= CHECK;
            end
          end
          CHECK: begin
            if (w_byte == r_csum) begin
              r_frame_valid <= 1'b1;
              r_state       <= HOLD;
            end else begin
              r_err_csum <= 1'b1;
              r_state    <= HUNT;
            end
          end
          default: begin
            r_state <= HUNT;
          end
        endcase
      end

      if ((r_state == HOLD) && bus.frame_ack) begin
        r_frame_valid <= 1'b0;
        r_state       <= HUNT;
      end
    end
  end

  frame_payload_ram #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (w_ram_we),
    .waddr (r_idx),
    .wdata (w_byte),
    .raddr (bus.buf_addr),
    .rdata (w_buf_data)
  );

  assign bus.rd_uart     = w_pop;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_cmd   = r_frame_cmd;
  assign bus.frame_len   = r_frame_len;
  assign bus.buf_data    = w_buf_data;
  assign bus.err_len     = r_err_len;
  assign bus.err_csum    = r_err_csum;
  assign bus.err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_frame_rx : directed frames through a modelled UART RX FIFO
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         last_pop = 0;
  int         pops     = 0;
  int         n_err_len  = 0;
  int         n_err_csum = 0;
  int         n_err_to   = 0;
  logic       take = 1'b0;
  logic [7:0] q[$];

  uart_frame_rx_if #(.MAX_LEN(16)) bus();

  uart_frame_rx #(
    .MAX_LEN   (16),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (100),
    .TO_W      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Upstream FIFO: retire the byte popped at the last edge, present the next one,
  // then sample rd_uart just before the coming edge.
  always @(negedge clk) begin
    if (take && q.size() != 0) void'(q.pop_front());
    bus.rx_empty = (q.size() == 0);
    bus.r_data   = (q.size() != 0) ? q[0] : 8'h00;
    #3;
    take = bus.rd_uart;
    if (take) begin
      last_pop = cyc;
      pops++;
    end
  end

  always @(negedge clk) begin
    if (bus.err_len === 1'b1)     n_err_len++;
    if (bus.err_csum === 1'b1)    n_err_csum++;
    if (bus.err_timeout === 1'b1) n_err_to++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_seq(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) q.push_back(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic read_buf(input logic [3:0] a, output logic [7:0] d);
    bus.buf_addr = a;
    @(negedge clk);
    d = bus.buf_data;
  endtask

  task automatic do_ack(input string name);
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
    n_checks++;
    if (bus.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ack_clear: frame_valid=%b required 0", name, bus.frame_valid);
    end
  endtask

  task automatic test_reset();
    bus.rx_empty  = 1'b1;
    bus.r_data    = 8'h00;
    bus.frame_ack = 1'b0;
    bus.buf_addr  = 4'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.frame_valid !== 1'b0 || bus.frame_cmd !== 8'h00 || bus.frame_len !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_frame: valid=%b cmd=%h len=%0d required 0/00/0",
               bus.frame_valid, bus.frame_cmd, bus.frame_len);
    end
    n_checks++;
    if (bus.buf_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_buf_data: got %h required 00", bus.buf_data);
    end
    n_checks++;
    if ({bus.err_len, bus.err_csum, bus.err_timeout} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_err: got %b required 000",
               {bus.err_len, bus.err_csum, bus.err_timeout});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.rd_uart !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rd_uart_empty: got %b required 0", bus.rd_uart);
    end
  endtask

  task automatic test_good_frame();
    bit ok;
    logic [7:0] d;
    int e0 = n_err_len + n_err_csum + n_err_to;
    push_seq(64'h00A5_1003_1122_3379, 7);
    wait_valid(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL good_valid: frame_valid=0 required 1"); end
    n_checks++;
    if (bus.frame_cmd !== 8'h10 || bus.frame_len !== 5'd3) begin
      n_fail++;
      $display("FAIL good_hdr: cmd=%h len=%0d required 10/3", bus.frame_cmd, bus.frame_len);
    end
    read_buf(4'd0, d);
    n_checks++;
    if (d !== 8'h11) begin n_fail++; $display("FAIL good_buf0: got %h required 11", d); end
    read_buf(4'd1, d);
    n_checks++;
    if (d !== 8'h22) begin n_fail++; $display("FAIL good_buf1: got %h required 22", d); end
    read_buf(4'd2, d);
    n_checks++;
    if (d !== 8'h33) begin n_fail++; $display("FAIL good_buf2: got %h required 33", d); end
    n_checks++;
    if (n_err_len + n_err_csum + n_err_to != e0) begin
      n_fail++;
      $display("FAIL good_no_err: %0d error pulses required 0", n_err_len + n_err_csum + n_err_to - e0);
    end
    do_ack("good");
  endtask

  task automatic test_bad_csum();
    bit ok;
    int c0 = n_err_csum;
    int o0 = n_err_len + n_err_to;
    push_seq(64'h00A5_1003_1122_3378, 7);
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_err_csum - c0 != 1) begin
      n_fail++;
      $display("FAIL csum_pulse: %0d err_csum cycles required 1", n_err_csum - c0);
    end
    n_checks++;
    if (bus.frame_valid !== 1'b0 || n_err_len + n_err_to != o0) begin
      n_fail++;
      $display("FAIL csum_side: valid=%b other_err=%0d required 0/0", bus.frame_valid, n_err_len + n_err_to - o0);
    end
    push_seq(64'h00A5_1003_1122_3379, 7);
    wait_valid(60, ok);
    n_checks++;
    if (!ok || bus.frame_cmd !== 8'h10 || bus.frame_len !== 5'd3) begin
      n_fail++;
      $display("FAIL csum_recover: valid=%b cmd=%h len=%0d required 1/10/3", ok, bus.frame_cmd, bus.frame_len);
    end
    do_ack("csum");
  endtask

  task automatic test_zero_len_garbage();
    bit ok;
    int e0 = n_err_len + n_err_csum + n_err_to;
    push_seq(64'h0000_00FF_A520_0020, 6);
    wait_valid(60, ok);
    n_checks++;
    if (!ok || bus.frame_cmd !== 8'h20 || bus.frame_len !== 5'd0) begin
      n_fail++;
      $display("FAIL zero_len: valid=%b cmd=%h len=%0d required 1/20/0", ok, bus.frame_cmd, bus.frame_len);
    end
    n_checks++;
    if (n_err_len + n_err_csum + n_err_to != e0) begin
      n_fail++;
      $display("FAIL zero_len_err: %0d error pulses required 0", n_err_len + n_err_csum + n_err_to - e0);
    end
    do_ack("zero");
  endtask

  task automatic test_len_bounds();
    bit ok;
    logic [7:0] d;
    int l0 = n_err_len;
    push_seq(64'h0000_0000_00A5_0111, 3);
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_err_len - l0 != 1 || bus.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL len_over: err_len cycles=%0d valid=%b required 1/0", n_err_len - l0, bus.frame_valid);
    end
    push_seq(64'h0000_00A5_0101_ABAD, 5);
    wait_valid(60, ok);
    read_buf(4'd0, d);
    n_checks++;
    if (!ok || bus.frame_cmd !== 8'h01 || bus.frame_len !== 5'd1 || d !== 8'hAB) begin
      n_fail++;
      $display("FAIL len_recover: valid=%b cmd=%h len=%0d buf0=%h required 1/01/1/AB",
               ok, bus.frame_cmd, bus.frame_len, d);
    end
    do_ack("len1");
    // LEN equal to MAX_LEN is legal: payload 00..0F, checksum 02+10+78 = 8A.
    push_seq(64'h0000_0000_00A5_0210, 3);
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    q.push_back(8'h8A);
    wait_valid(80, ok);
    n_checks++;
    if (!ok || bus.frame_len !== 5'd16 || n_err_len != l0 + 1) begin
      n_fail++;
      $display("FAIL len_max: valid=%b len=%0d err_len=%0d required 1/16/%0d", ok, bus.frame_len, n_err_len, l0 + 1);
    end
    read_buf(4'd15, d);
    n_checks++;
    if (d !== 8'h0F) begin n_fail++; $display("FAIL len_max_buf15: got %h required 0F", d); end
    read_buf(4'd0, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL len_max_buf0: got %h required 00", d); end
    do_ack("lenmax");
  endtask

  task automatic test_timeout();
    bit seen = 1'b0;
    bit ok;
    int gap = 0;
    int t0 = n_err_to;
    push_seq(64'h0000_0000_0000_A510, 2);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.err_timeout === 1'b1) begin
        seen = 1'b1;
        gap  = cyc - last_pop;
        break;
      end
    end
    n_checks++;
    if (!seen || gap != 101) begin
      n_fail++;
      $display("FAIL timeout_timing: seen=%b gap=%0d required 1/101", seen, gap);
    end
    push_seq(64'h0000_0000_0000_0003, 1);
    repeat (150) @(negedge clk);
    n_checks++;
    if (n_err_to - t0 != 1 || bus.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_hunt: err_timeout cycles=%0d valid=%b required 1/0", n_err_to - t0, bus.frame_valid);
    end
    push_seq(64'h00A5_1003_1122_3379, 7);
    wait_valid(60, ok);
    n_checks++;
    if (!ok || bus.frame_cmd !== 8'h10 || bus.frame_len !== 5'd3) begin
      n_fail++;
      $display("FAIL timeout_recover: valid=%b cmd=%h len=%0d required 1/10/3", ok, bus.frame_cmd, bus.frame_len);
    end
    do_ack("timeout");
  endtask

  task automatic test_back_to_back();
    bit ok;
    int p0;
    logic [7:0] d;
    // Second frame sums 33+02+FE+03 = 136, wrapping to 36.
    push_seq(64'h00A5_1003_1122_3379, 7);
    push_seq(64'h0000_A533_02FE_0336, 6);
    wait_valid(60, ok);
    p0 = pops;
    repeat (10) @(negedge clk);
    n_checks++;
    if (!ok || bus.rd_uart !== 1'b0 || pops != p0 || q.size() != 6) begin
      n_fail++;
      $display("FAIL hold_backpressure: valid=%b rd_uart=%b pops=%0d fifo=%0d required 1/0/0/6",
               ok, bus.rd_uart, pops - p0, q.size());
    end
    read_buf(4'd2, d);
    n_checks++;
    if (bus.frame_cmd !== 8'h10 || bus.frame_len !== 5'd3 || d !== 8'h33) begin
      n_fail++;
      $display("FAIL hold_stable: cmd=%h len=%0d buf2=%h required 10/3/33", bus.frame_cmd, bus.frame_len, d);
    end
    do_ack("b2b1");
    wait_valid(60, ok);
    n_checks++;
    if (!ok || bus.frame_cmd !== 8'h33 || bus.frame_len !== 5'd2) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b cmd=%h len=%0d required 1/33/2", ok, bus.frame_cmd, bus.frame_len);
    end
    read_buf(4'd0, d);
    n_checks++;
    if (d !== 8'hFE) begin n_fail++; $display("FAIL b2b_buf0: got %h required FE", d); end
    read_buf(4'd1, d);
    n_checks++;
    if (d !== 8'h03) begin n_fail++; $display("FAIL b2b_buf1: got %h required 03", d); end
    do_ack("b2b2");
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] d;
    bus.buf_addr = 4'd0;
    push_seq(64'h0000_0000_A510_0311, 4);
    repeat (8) @(negedge clk);
    q.delete();
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.frame_valid !== 1'b0 || bus.frame_cmd !== 8'h00 || bus.frame_len !== 5'd0 ||
        bus.buf_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_outputs: valid=%b cmd=%h len=%0d buf=%h required 0/00/0/00",
               bus.frame_valid, bus.frame_cmd, bus.frame_len, bus.buf_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_seq(64'h0000_00A5_4401_559A, 5);
    wait_valid(60, ok);
    read_buf(4'd0, d);
    n_checks++;
    if (!ok || bus.frame_cmd !== 8'h44 || bus.frame_len !== 5'd1 || d !== 8'h55) begin
      n_fail++;
      $display("FAIL midreset_restart: valid=%b cmd=%h len=%0d buf0=%h required 1/44/1/55",
               ok, bus.frame_cmd, bus.frame_len, d);
    end
    do_ack("midreset");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_zero_len_garbage();
    test_len_bounds();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
